// File: rtl/dsp_dot_seq.sv
// dsp_dot_seq: streams signed operand pairs into an external 3-stage
// dsp_slice, schedules its multiply/accumulate pins, collects the dot product.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_a/in_b/in_last
// operand stream; out_valid/out_ready/out_data result; dsp_ax/ay/az,
// dsp_multiply, dsp_accumulate to the slice; dsp_result from the slice.
// Optional: define DOT_SEQ_COUNT_EN to add the out_count beat counter.
module dsp_dot_seq #(
  parameter int DWIDTH = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
`ifdef DOT_SEQ_COUNT_EN
  output logic [CNT_W-1:0]  out_count,
`endif
  output logic [DWIDTH-1:0] dsp_ax,
  output logic [DWIDTH-1:0] dsp_ay,
  output logic [DWIDTH-1:0] dsp_az,
  output logic              dsp_multiply,
  output logic              dsp_accumulate,
  input  logic [DWIDTH-1:0] dsp_result
);

  typedef struct packed {
    logic v;
    logic f;
    logic l;
  } tag_t;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DWIDTH-1:0] out_data_q;
  tag_t              s1_d, s1_q, s2_q, s3_q;
  logic              first_q;
  logic              fire;
  logic              capture;

  assign fire    = in_valid & in_ready_q;
  assign capture = (state_q == DRAIN) & s3_q.v & s3_q.l;

  // Idle cycles feed zero operands so the slice adds a zero product.
  assign dsp_ax = '0;
  assign dsp_ay = fire ? in_a : '0;
  assign dsp_az = fire ? in_b : '0;

  // s2 lines up with the slice's product register: first beat loads,
  // everything else (including bubbles and idle) accumulates.
  assign dsp_multiply   = s2_q.v & s2_q.f;
  assign dsp_accumulate = ~(s2_q.v & s2_q.f);

  assign s1_d.v = fire;
  assign s1_d.f = fire & first_q;
  assign s1_d.l = fire & in_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      first_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (fire) first_q <= in_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACC;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (fire && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (capture) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_data_q  <= dsp_result;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DOT_SEQ_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_last_q;
  logic [CNT_W-1:0] out_count_q;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // The count is parked at the last beat, since the result only
  // arrives three cycles later and the counter restarts at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      cnt_last_q  <= '0;
      out_count_q <= '0;
    end else begin
      if (fire) begin
        if (in_last) begin
          cnt_q      <= '0;
          cnt_last_q <= cnt_inc;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
      if (capture) out_count_q <= cnt_last_q;
    end
  end

  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_dsp_dot_seq.sv
// tb_dsp_dot_seq: drives dsp_dot_seq against a behavioural dsp_slice and
// compares each dot product with a plain-arithmetic reference.
module tb_dsp_dot_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic        out_valid, out_ready;
  logic [15:0] in_a, in_b, out_data;
  logic [15:0] dsp_ax, dsp_ay, dsp_az, dsp_result;
  logic        dsp_multiply, dsp_accumulate;
`ifdef DOT_SEQ_COUNT_EN
  logic [7:0]  out_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int av[16];
  int bv[16];

  always #5 clk = ~clk;

  dsp_dot_seq #(.DWIDTH(16), .CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef DOT_SEQ_COUNT_EN
    .out_count(out_count),
`endif
    .dsp_ax(dsp_ax),
    .dsp_ay(dsp_ay),
    .dsp_az(dsp_az),
    .dsp_multiply(dsp_multiply),
    .dsp_accumulate(dsp_accumulate),
    .dsp_result(dsp_result)
  );

  function automatic int sat(int p);
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  // Behavioural slice: operand reg, saturating product reg, result reg.
  logic signed [15:0] sy, sz;
  logic [15:0]        sprod, sres;
  int                 sp;
  assign sp         = sat(int'(sy) * int'(sz));
  assign dsp_result = sres;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sy <= '0; sz <= '0; sprod <= '0; sres <= '0;
    end else begin
      sy    <= dsp_ay;
      sz    <= dsp_az;
      sprod <= sp[15:0];
      if (dsp_multiply) sres <= sprod;
      else if (dsp_accumulate) sres <= sres + sprod;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(int n);
    int acc = 0;
    for (int i = 0; i < n; i++) acc += sat(av[i] * bv[i]);
    return acc[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(int n, int gap, int hold);
    int cnt, mc, ma;
    logic [15:0] exp;
    exp = model(n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) tick();
      in_valid = 1'b1;
      in_a     = av[i][15:0];
      in_b     = bv[i][15:0];
      in_last  = (i == n - 1);
      check("in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_a     = '0;
      in_b     = '0;
    end
    cnt = 1; mc = 0; ma = 0;
    while (!out_valid && cnt < 12) begin
      check("drain_rdy", in_ready, 0);
      if (dsp_multiply) begin mc++; ma = cnt; end
      tick();
      cnt++;
    end
    check("latency", cnt, 4);
    if (n == 1) begin
      check("mult_n", mc, 1);
      check("mult_at", ma, 2);
    end
    check("out_data", out_data, exp);
`ifdef DOT_SEQ_COUNT_EN
    check("out_count", out_count, (n > 255) ? 255 : n);
`endif
    repeat (hold) begin
      tick();
      check("hold_vld", out_valid, 1);
      check("hold_data", out_data, exp);
      check("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("vld_fall", out_valid, 0);
    check("rdy_back", in_ready, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_rdy", in_ready, 1);
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_mul", dsp_multiply, 0);
    check("rst_acc", dsp_accumulate, 1);
    check("rst_ay", dsp_ay, 0);
    check("rst_ax", dsp_ax, 0);
`ifdef DOT_SEQ_COUNT_EN
    check("rst_cnt", out_count, 0);
`endif

    av[0] = 1; av[1] = 2; av[2] = 3;
    bv[0] = 4; bv[1] = 5; bv[2] = 6;
    run_vec(3, 0, 0);
    run_vec(3, 2, 0);

    av[0] = -3; bv[0] = 5;
    run_vec(1, 0, 0);
    check("single_val", model(1), 16'hFFF1);

    av[0] = 200; av[1] = 1; bv[0] = 200; bv[1] = 1;
    run_vec(2, 0, 0);
    check("wrap_val", model(2), 16'h8000);

    av[0] = 5; av[1] = -7; bv[0] = 9; bv[1] = 3;
    run_vec(2, 0, 10);
    av[0] = 2; bv[0] = 2;
    run_vec(1, 0, 0);

    // Two beats then reset: partial sum must vanish.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'd100; in_b = 16'd100; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    check("mrst_vld", out_valid, 0);
    check("mrst_rdy", in_ready, 1);
    av[0] = 7; bv[0] = 1;
    run_vec(1, 0, 0);

    for (int v = 0; v < 30; v++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          av[i] = int'($urandom_range(0, 600)) - 300;
          bv[i] = int'($urandom_range(0, 600)) - 300;
        end else begin
          av[i] = int'($urandom_range(0, 65535)) - 32768;
          bv[i] = int'($urandom_range(0, 65535)) - 32768;
        end
      end
      run_vec(n, $urandom_range(0, 2), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
